// File: rtl/pad_gpio_ctrl.sv
// rtl/pad_gpio_ctrl.sv - N-channel GPIO controller for sg13g2 bidirectional pad cells
// Registered push-pull/open-drain drive, synchronised debounced inputs, sticky edge IRQs.
module pad_gpio_ctrl #(
   parameter int unsigned NumPads    = 8,
   parameter int unsigned SyncStages = 2,
   parameter int unsigned DebCycles  = 4,
   parameter int unsigned CntWidth   = $clog2(DebCycles + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumPads-1:0] cfg_dir_i,
   input  logic [NumPads-1:0] cfg_od_i,
   input  logic [NumPads-1:0] cfg_deb_en_i,
   input  logic [NumPads-1:0] gpio_out_i,
   input  logic [NumPads-1:0] irq_rise_en_i,
   input  logic [NumPads-1:0] irq_fall_en_i,
   input  logic [NumPads-1:0] irq_clr_i,
   output logic [NumPads-1:0] gpio_in_o,
   output logic [NumPads-1:0] irq_status_o,
   output logic               irq_o,
   input  logic [NumPads-1:0] pad_in_i,
   output logic [NumPads-1:0] pad_out_o,
   output logic [NumPads-1:0] pad_oen_o
);

   localparam int unsigned ArmCycles = SyncStages + DebCycles + 1;
   localparam int unsigned ArmWidth  = $clog2(ArmCycles + 1);
   localparam logic [CntWidth-1:0] DebLast = CntWidth'(DebCycles - 1);
   localparam logic [ArmWidth-1:0] ArmLast = ArmWidth'(ArmCycles - 1);

   logic [NumPads-1:0]  sync_q [SyncStages];
   logic [NumPads-1:0]  sync;
   logic [NumPads-1:0]  gpio_in_q;
   logic [NumPads-1:0]  deb_en_q;
   logic [CntWidth-1:0] cnt_q [NumPads];
   logic [NumPads-1:0]  prev_q;
   logic [NumPads-1:0]  status_q;
   logic [NumPads-1:0]  status_d;
   logic [NumPads-1:0]  rise;
   logic [NumPads-1:0]  fall;
   logic                irq_q;
   logic [ArmWidth-1:0] arm_cnt_q;
   logic                armed_q;
   logic [NumPads-1:0]  pad_out_q;
   logic [NumPads-1:0]  pad_oen_q;

   // Open-drain only ever drives a low; a high output is a released pad.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pad_out_q <= '0;
         pad_oen_q <= '1;
      end else begin
         pad_out_q <= gpio_out_i & ~cfg_od_i;
         pad_oen_q <= ~(cfg_dir_i & (~cfg_od_i | ~gpio_out_i));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < SyncStages; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= pad_in_i;
         for (int k = 1; k < SyncStages; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync = sync_q[SyncStages-1];

   // A change of the debounce enable restarts the count so a stale partial count is not reused.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gpio_in_q <= '0;
         deb_en_q  <= '0;
         for (int i = 0; i < NumPads; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_en_q <= cfg_deb_en_i;
         for (int i = 0; i < NumPads; i++) begin
            if (!cfg_deb_en_i[i]) begin
               gpio_in_q[i] <= sync[i];
               cnt_q[i]     <= '0;
            end else if (cfg_deb_en_i[i] != deb_en_q[i]) begin
               cnt_q[i] <= '0;
            end else if (sync[i] == gpio_in_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DebLast) begin
               gpio_in_q[i] <= ~gpio_in_q[i];
               cnt_q[i]     <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Hold off edge detection until the filtered inputs have settled after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         arm_cnt_q <= '0;
         armed_q   <= 1'b0;
      end else if (!armed_q) begin
         if (arm_cnt_q == ArmLast) begin
            armed_q <= 1'b1;
         end else begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      rise     = {NumPads{armed_q}} & gpio_in_q & ~prev_q;
      fall     = {NumPads{armed_q}} & ~gpio_in_q & prev_q;
      status_d = (status_q & ~irq_clr_i) | (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q   <= '0;
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         prev_q   <= gpio_in_q;
         status_q <= status_d;
         irq_q    <= |status_d;
      end
   end

   assign gpio_in_o    = gpio_in_q;
   assign irq_status_o = status_q;
   assign irq_o        = irq_q;
   assign pad_out_o    = pad_out_q;
   assign pad_oen_o    = pad_oen_q;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// tb/tb_pad_gpio_ctrl.sv - directed self-checking bench for pad_gpio_ctrl
module tb_pad_gpio_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] cfg_dir, cfg_od, cfg_deb_en, gpio_out;
   logic [7:0] irq_rise_en, irq_fall_en, irq_clr;
   logic [7:0] gpio_in, irq_status, pad_in, pad_out, pad_oen;
   logic       irq;

   int tests = 0;
   int fails = 0;

   pad_gpio_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_dir_i     (cfg_dir),
      .cfg_od_i      (cfg_od),
      .cfg_deb_en_i  (cfg_deb_en),
      .gpio_out_i    (gpio_out),
      .irq_rise_en_i (irq_rise_en),
      .irq_fall_en_i (irq_fall_en),
      .irq_clr_i     (irq_clr),
      .gpio_in_o     (gpio_in),
      .irq_status_o  (irq_status),
      .irq_o         (irq),
      .pad_in_i      (pad_in),
      .pad_out_o     (pad_out),
      .pad_oen_o     (pad_oen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      cfg_dir = 8'h00; cfg_od = 8'h00; cfg_deb_en = 8'hFF; gpio_out = 8'h00;
      irq_rise_en = 8'hFF; irq_fall_en = 8'h00; irq_clr = 8'h00;
      pad_in = 8'hFF;
      tick(2);
      chk("rst_oen", 32'(pad_oen), 32'hFF);
      chk("rst_out", 32'(pad_out), 32'h00);
      chk("rst_gpio_in", 32'(gpio_in), 32'h00);
      chk("rst_status", 32'(irq_status), 32'h00);
      chk("rst_irq", 32'(irq), 32'h0);

      // Reset release with all pads high
      rst = 1'b0;
      tick(5);
      chk("rel_gpio_in_5", 32'(gpio_in), 32'h00);
      tick(1);
      chk("rel_gpio_in_6", 32'(gpio_in), 32'hFF);
      for (int c = 0; c < 100; c++) begin
         tick(1);
         chk("rel_no_irq", 32'(irq), 32'h0);
      end
      chk("rel_oen", 32'(pad_oen), 32'hFF);
      chk("rel_status", 32'(irq_status), 32'h00);

      // Push-pull on ch0
      cfg_dir[0] = 1'b1;
      tick(1);
      chk("pp_oen0", 32'(pad_oen[0]), 32'h0);
      chk("pp_out0_lo", 32'(pad_out[0]), 32'h0);
      gpio_out[0] = 1'b1;
      #1;
      chk("pp_out0_reg", 32'(pad_out[0]), 32'h0);
      tick(1);
      chk("pp_out0_hi", 32'(pad_out[0]), 32'h1);
      chk("pp_oen0_hi", 32'(pad_oen[0]), 32'h0);

      // Open-drain on ch3
      cfg_dir[3] = 1'b1; cfg_od[3] = 1'b1; gpio_out[3] = 1'b0;
      tick(1);
      chk("od_oen3_lo", 32'(pad_oen[3]), 32'h0);
      chk("od_out3_lo", 32'(pad_out[3]), 32'h0);
      gpio_out[3] = 1'b1;
      tick(1);
      chk("od_oen3_hi", 32'(pad_oen[3]), 32'h1);
      chk("od_out3_hi", 32'(pad_out[3]), 32'h0);

      // Debounce on ch2
      pad_in[2] = 1'b0;
      tick(10);
      chk("deb_ch2_low", 32'(gpio_in[2]), 32'h0);
      chk("deb_fall_no_irq", 32'(irq_status), 32'h00);
      pad_in[2] = 1'b1;
      tick(3);
      pad_in[2] = 1'b0;
      tick(10);
      chk("glitch3_gpio", 32'(gpio_in[2]), 32'h0);
      chk("glitch3_status", 32'(irq_status), 32'h00);
      chk("glitch3_irq", 32'(irq), 32'h0);
      pad_in[2] = 1'b1;
      tick(4);
      pad_in[2] = 1'b0;
      tick(1);
      chk("pulse4_gpio_5", 32'(gpio_in[2]), 32'h0);
      tick(1);
      chk("pulse4_gpio_6", 32'(gpio_in[2]), 32'h1);
      tick(1);
      chk("pulse4_status", 32'(irq_status), 32'h04);
      chk("pulse4_irq", 32'(irq), 32'h1);
      tick(10);
      irq_clr = 8'h04;
      tick(1);
      irq_clr = 8'h00;
      chk("pulse4_clr_status", 32'(irq_status), 32'h00);
      chk("pulse4_clr_irq", 32'(irq), 32'h0);

      // Set-and-clear collision on ch1
      pad_in[1] = 1'b0;
      tick(10);
      pad_in[1] = 1'b1;
      tick(6);
      chk("coll_pre_status", 32'(irq_status), 32'h00);
      irq_clr = 8'h02;
      tick(1);
      irq_clr = 8'h00;
      chk("coll_status", 32'(irq_status), 32'h02);
      chk("coll_irq", 32'(irq), 32'h1);
      irq_rise_en = 8'h00;
      tick(2);
      chk("en_change_keeps", 32'(irq_status), 32'h02);
      irq_rise_en = 8'hFF;
      irq_clr = 8'h02;
      tick(1);
      irq_clr = 8'h00;
      chk("lone_clr_status", 32'(irq_status), 32'h00);
      chk("lone_clr_irq", 32'(irq), 32'h0);

      // Debounce bypass on ch4
      cfg_deb_en[4] = 1'b0;
      tick(2);
      pad_in[4] = 1'b0;
      tick(2);
      chk("byp_gpio4_2", 32'(gpio_in[4]), 32'h1);
      tick(1);
      chk("byp_gpio4_3", 32'(gpio_in[4]), 32'h0);
      tick(5);

      // Reset in the middle of a debounce count on ch1
      pad_in[1] = 1'b0;
      tick(4);
      chk("pre_rst_oen", 32'(pad_oen), 32'hFE);
      chk("pre_rst_out", 32'(pad_out), 32'h01);
      chk("pre_rst_gpio1", 32'(gpio_in[1]), 32'h1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_oen", 32'(pad_oen), 32'hFF);
      chk("mid_rst_out", 32'(pad_out), 32'h00);
      chk("mid_rst_gpio", 32'(gpio_in), 32'h00);
      chk("mid_rst_status", 32'(irq_status), 32'h00);
      for (int c = 0; c < 30; c++) begin
         tick(1);
         chk("post_rst_no_irq", 32'(irq), 32'h0);
      end
      chk("post_rst_gpio", 32'(gpio_in), 32'hE9);
      chk("post_rst_status", 32'(irq_status), 32'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
